// File: rtl/trace_capture_fifo.sv
// Trace capture FIFO between the CPU trace port and the cosim comparator: tags words with a
// sequence number, counts branch/irq/drop events. Optional macro TRACE_CAPTURE_TIMESTAMP_EN adds out_cycle.
module trace_capture_fifo #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned AW          = 6,
  parameter bit          STOP_ON_OVF = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          trap,
  input  logic          trace_valid,
  input  logic [35:0]   trace_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [35:0]   out_data,
  output logic [31:0]   out_seq,
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  output logic [31:0]   out_cycle,
`endif
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [15:0]   dropped_count,
  output logic [31:0]   branch_count,
  output logic [31:0]   irq_count,
  output logic [1:0]    state_o
);

  localparam int unsigned DW = 36;
  localparam int unsigned SW = 32;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  localparam int unsigned EW = DW + SW + 32;
`else
  localparam int unsigned EW = DW + SW;
`endif
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic [EW-1:0]   new_entry;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [31:0]     seq;
  logic            full, pop, push, drop, mem_empty, direct;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  logic [31:0]     cyc;
`endif

  // Handshake and push/drop decisions from the registered state
  always_comb begin
    full      = (level == FULL_LVL);
    pop       = out_valid && out_ready;
    push      = trace_valid && (state == S_RUN) && (!full || pop);
    drop      = trace_valid && (state == S_RUN) && full && !pop;
    mem_empty = (wr_ptr == rd_ptr);
    // A new word bypasses the RAM when the head register is (or becomes) free
    direct    = push && (!out_valid || (pop && mem_empty));
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    new_entry = {cyc, seq, trace_data};
`else
    new_entry = {seq, trace_data};
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable) state_nxt = S_RUN;
      S_RUN: begin
        if (drop && STOP_ON_OVF) state_nxt = S_HALT;
        else if (trap)           state_nxt = S_DRAIN;
        else if (!enable)        state_nxt = S_IDLE;
      end
      S_DRAIN: if (level == '0) state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Backing RAM holds everything behind the head register
  always_ff @(posedge clk) begin
    if (push && !direct) mem[wr_ptr[AW-1:0]] <= new_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      out_valid <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      if (direct)                head <= new_entry;
      else if (pop && !mem_empty) head <= mem[rd_ptr[AW-1:0]];
      if (direct)                out_valid <= 1'b1;
      else if (pop && mem_empty) out_valid <= 1'b0;
      if (push && !direct)       wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !mem_empty)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && !pop)          level <= level + (AW+1)'(1);
      else if (pop && !push)     level <= level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq           <= '0;
      branch_count  <= '0;
      irq_count     <= '0;
      dropped_count <= '0;
      overflow      <= 1'b0;
    end else begin
      if (push) begin
        seq <= seq + 32'd1;
        if (trace_data[32]) branch_count <= branch_count + 32'd1;
        if (trace_data[35]) irq_count    <= irq_count + 32'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
      end
    end
  end

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end
  assign out_cycle = head[DW+SW +: 32];
`endif

  assign out_data = head[DW-1:0];
  assign out_seq  = head[DW +: SW];
  assign state_o  = state;

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Self-checking bench for trace_capture_fifo: vector table, corner-case sequences and a
// randomized run against a queue-based reference of the capture rules.
module tb_trace_capture_fifo;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic        clk = 1'b0;
  logic        reset, enable, trap, tv, rdy;
  logic [35:0] td;

  logic        v0, v1, ovf0, ovf1;
  logic [35:0] d0, d1;
  logic [31:0] s0, s1, br0, br1, irq0, irq1;
  logic [AW:0] lvl0, lvl1;
  logic [15:0] drp0, drp1;
  logic [1:0]  st0, st1;
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  logic [31:0] cyc0, cyc1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  trace_capture_fifo #(.DEPTH(DEPTH), .AW(AW), .STOP_ON_OVF(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .trap(trap),
    .trace_valid(tv), .trace_data(td),
    .out_valid(v0), .out_ready(rdy), .out_data(d0), .out_seq(s0),
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    .out_cycle(cyc0),
`endif
    .level(lvl0), .overflow(ovf0), .dropped_count(drp0),
    .branch_count(br0), .irq_count(irq0), .state_o(st0)
  );

  trace_capture_fifo #(.DEPTH(DEPTH), .AW(AW), .STOP_ON_OVF(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .trap(trap),
    .trace_valid(tv), .trace_data(td),
    .out_valid(v1), .out_ready(rdy), .out_data(d1), .out_seq(s1),
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
    .out_cycle(cyc1),
`endif
    .level(lvl1), .overflow(ovf1), .dropped_count(drp1),
    .branch_count(br1), .irq_count(irq1), .state_o(st1)
  );

  // Reference for dut0 (no stop on overflow): a queue of {seq, word}
  logic [67:0] mq[$];
  int          m_state;
  logic [31:0] m_seq, m_branch, m_irq;
  logic [15:0] m_drop;
  logic        m_ovf;

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_seq = '0; m_branch = '0; m_irq = '0; m_drop = '0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit pop_m, full_m, push_m, drop_m;
    int nxt;
    pop_m  = (mq.size() > 0) && rdy;
    full_m = (mq.size() == DEPTH);
    push_m = tv && (m_state == 1) && (!full_m || pop_m);
    drop_m = tv && (m_state == 1) && full_m && !pop_m;
    nxt = m_state;
    case (m_state)
      0: if (enable) nxt = 1;
      1: if (trap) nxt = 2; else if (!enable) nxt = 0;
      2: if (mq.size() == 0) nxt = 3;
      default: nxt = 3;
    endcase
    if (pop_m) mq.delete(0);
    if (push_m) begin
      mq.push_back({m_seq, td});
      m_seq = m_seq + 32'd1;
      if (td[32]) m_branch = m_branch + 32'd1;
      if (td[35]) m_irq = m_irq + 32'd1;
    end
    if (drop_m) begin
      m_ovf = 1'b1;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    m_state = nxt;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [67:0] h;
    chk("m_valid",  64'(v0),   64'(mq.size() > 0));
    chk("m_level",  64'(lvl0), 64'(mq.size()));
    chk("m_state",  64'(st0),  64'(m_state));
    chk("m_ovf",    64'(ovf0), 64'(m_ovf));
    chk("m_drop",   64'(drp0), 64'(m_drop));
    chk("m_branch", 64'(br0),  64'(m_branch));
    chk("m_irq",    64'(irq0), 64'(m_irq));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("m_data", 64'(d0), 64'(h[35:0]));
      chk("m_seq",  64'(s0), 64'(h[67:36]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; trap = 1'b0; tv = 1'b0; td = '0; rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_model();
    chk("rst_seq", 64'(s0), 64'd0);
    chk("rst_data", 64'(d0), 64'd0);
  endtask

  task automatic push_words(input int n, input logic [3:0] flags);
    for (int i = 0; i < n; i++) begin
      tv = 1'b1; td = {flags, 32'(i) + 32'h1000};
      tick();
    end
    tv = 1'b0;
  endtask

  typedef struct {
    logic        tv;
    logic [35:0] d;
    logic        rdy;
    logic        ev;
    logic [35:0] ed;
    logic [31:0] es;
    int          el;
  } vec_t;

  vec_t t1[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    t1[0] = '{1'b1, 36'h0_00000100, 1'b1, 1'b1, 36'h0_00000100, 32'd0, 1};
    t1[1] = '{1'b1, 36'h1_00000104, 1'b1, 1'b1, 36'h1_00000104, 32'd1, 1};
    t1[2] = '{1'b1, 36'h8_00000010, 1'b1, 1'b1, 36'h8_00000010, 32'd2, 1};
    t1[3] = '{1'b0, 36'h0,          1'b1, 1'b0, 36'h0,          32'd0, 0};

    // Test 1: three words through with consumer always ready
    do_reset();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tv = t1[i].tv; td = t1[i].d; rdy = t1[i].rdy;
      tick();
      chk("t1_valid", 64'(v0), 64'(t1[i].ev));
      chk("t1_level", 64'(lvl0), 64'(t1[i].el));
      if (t1[i].ev) begin
        chk("t1_data", 64'(d0), 64'(t1[i].ed));
        chk("t1_seq",  64'(s0), 64'(t1[i].es));
      end
    end
    chk("t1_branch", 64'(br0), 64'd1);
    chk("t1_irq",    64'(irq0), 64'd1);

    // Tests 2/3: overflow with and without stop
    do_reset();
    enable = 1'b1;
    tick();
    push_words(DEPTH + 3, 4'h0);
    chk("t2_level", 64'(lvl0), 64'(DEPTH));
    chk("t2_ovf",   64'(ovf0), 64'd1);
    chk("t2_drop",  64'(drp0), 64'd3);
    chk("t2_state", 64'(st0),  64'd1);
    chk("t3_state", 64'(st1),  64'd3);
    chk("t3_drop",  64'(drp1), 64'd1);
    chk("t3_level", 64'(lvl1), 64'(DEPTH));
    push_words(3, 4'h0);
    chk("t3_drop_hold", 64'(drp1), 64'd1);
    chk("t2_drop6",     64'(drp0), 64'd6);
    rdy = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      chk("t3_valid", 64'(v1), 64'd1);
      chk("t3_seq",   64'(s1), 64'(k));
      chk("t2_seq",   64'(s0), 64'(k));
      tick();
    end
    chk("t3_empty", 64'(lvl1), 64'd0);
    chk("t3_novalid", 64'(v1), 64'd0);

    // Test 4: push and pop together while full
    do_reset();
    enable = 1'b1;
    tick();
    push_words(DEPTH, 4'h0);
    chk("t4_full", 64'(lvl0), 64'(DEPTH));
    tv = 1'b1; rdy = 1'b1; td = 36'h2_DEADBEEF;
    tick();
    tv = 1'b0; rdy = 1'b0;
    chk("t4_level", 64'(lvl0), 64'(DEPTH));
    chk("t4_drop",  64'(drp0), 64'd0);
    chk("t4_seq",   64'(s0),   64'd1);

    // Test 5: trap with a word, then drain to HALT
    do_reset();
    enable = 1'b1;
    tick();
    push_words(5, 4'h1);
    trap = 1'b1; tv = 1'b1; td = 36'h8_00000555;
    tick();
    trap = 1'b0; tv = 1'b0;
    chk("t5_state", 64'(st0), 64'd2);
    chk("t5_level", 64'(lvl0), 64'd6);
    rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t5_valid", 64'(v0), 64'd1);
      chk("t5_seq",   64'(s0), 64'(k));
      tick();
    end
    chk("t5_empty", 64'(lvl0), 64'd0);
    begin
      int w = 0;
      while (st0 != 2'd3 && w < 10) begin tick(); w++; end
    end
    chk("t5_halt", 64'(st0), 64'd3);
    rdy = 1'b0;

    // Test 6: asynchronous reset in the middle of a drain
    do_reset();
    enable = 1'b1;
    tick();
    push_words(9, 4'h9);
    trap = 1'b1; tv = 1'b1; td = 36'h9_0000ABCD;
    tick();
    trap = 1'b0; tv = 1'b0;
    chk("t6_level_pre", 64'(lvl0), 64'd10);
    chk("t6_state_pre", 64'(st0), 64'd2);
    #1 reset = 1'b1;
    #1;
    chk("t6_valid", 64'(v0),   64'd0);
    chk("t6_level", 64'(lvl0), 64'd0);
    chk("t6_state", 64'(st0),  64'd0);
    chk("t6_branch", 64'(br0), 64'd0);
    chk("t6_irq",   64'(irq0), 64'd0);
    chk("t6_seqo",  64'(s0),   64'd0);
    chk("t6_ovf",   64'(ovf0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    enable = 1'b1;
    tick();
    tv = 1'b1; td = 36'h0_00000042;
    tick();
    tv = 1'b0;
    chk("t6_seq_restart", 64'(s0), 64'd0);

    // Randomized traffic with varying consumer back-pressure
    for (int s = 0; s < 3; s++) begin
      int rdy_pct;
      rdy_pct = (s == 0) ? 90 : (s == 1) ? 50 : 15;
      do_reset();
      enable = 1'b1;
      for (int c = 0; c < 1500; c++) begin
        enable = ($urandom_range(0, 99) < 97);
        trap   = ($urandom_range(0, 999) < 2);
        tv     = ($urandom_range(0, 99) < 60);
        rdy    = ($urandom_range(0, 99) < rdy_pct);
        td     = {4'($urandom_range(0, 15)), 32'($urandom)};
        tick();
      end
      trap = 1'b0; tv = 1'b0; rdy = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
